// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the Wishbone burst scheduler:
// FSM state encoding, Wishbone CTI/BTE codes and the end-of-burst test.
package wb_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_BURST   = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // A classic cycle or an end-of-burst marker makes the current beat the last one.
  function automatic logic cti_is_last(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter producing a one-hot grant.
// Default: round-robin, search starts at ptr_i and wraps upward.
// With WB_SCHED_FIXED_PRIO_EN defined: fixed priority, port 0 highest,
// and ptr_i is ignored.
module rr_arbiter
  import wb_sched_pkg::*;
#(
  parameter int NR_PORTS = 4,
  parameter int PW       = $clog2(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [NR_PORTS-1:0] gnt_o
);

`ifdef WB_SCHED_FIXED_PRIO_EN

  // Lowest-numbered requester wins.
  always_comb begin
    gnt_o = {NR_PORTS{1'b0}};
    for (int i = 0; i < NR_PORTS; i++) begin
      if (req_i[i] && (gnt_o == {NR_PORTS{1'b0}})) begin
        gnt_o[i] = 1'b1;
      end else begin
        gnt_o[i] = gnt_o[i];
      end
    end
  end

`else

  logic [PW:0]   sum_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // First set request at or after the pointer, wrapping past the top port.
  always_comb begin
    gnt_o   = {NR_PORTS{1'b0}};
    found_s = 1'b0;
    sum_s   = {(PW+1){1'b0}};
    idx_s   = {PW{1'b0}};
    for (int i = 0; i < NR_PORTS; i++) begin
      sum_s = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum_s >= (PW+1)'(NR_PORTS)) begin
        sum_s = sum_s - (PW+1)'(NR_PORTS);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PW-1:0];
      if (!found_s && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`endif

endmodule

// File: rtl/wb_burst_sched.sv
// Burst scheduler in front of the shared SDRAM address incrementer.
// Arbitrates Wishbone requesters, loads the winner's address/cti/bte with a
// one-cycle init pulse, paces inc by the winner's FIFO and acks each beat.
// Optional build macro: WB_SCHED_FIXED_PRIO_EN selects fixed priority
// (port 0 highest) and removes the round-robin pointer register.
module wb_burst_sched
  import wb_sched_pkg::*;
#(
  parameter int NR_PORTS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NR_PORTS-1:0]   req_i,
  input  logic [4*NR_PORTS-1:0] adr_i,
  input  logic [3*NR_PORTS-1:0] cti_i,
  input  logic [2*NR_PORTS-1:0] bte_i,
  input  logic [NR_PORTS-1:0]   fifo_empty_i,
  input  logic                  done_i,
  output logic                  init_o,
  output logic                  inc_o,
  output logic [3:0]            adr_o,
  output logic [2:0]            cti_o,
  output logic [1:0]            bte_o,
  output logic [NR_PORTS-1:0]   gnt_o,
  output logic [NR_PORTS-1:0]   ack_o,
  output logic                  busy_o
);

  localparam int PW = $clog2(NR_PORTS);

  state_e              state_q, state_d;
  logic [NR_PORTS-1:0] gnt_q, gnt_d;
  logic                init_q, init_d;
  logic                busy_q, busy_d;

  logic [NR_PORTS-1:0] arb_gnt_s;
  logic [PW-1:0]       ptr_s;
  logic [3:0]          adr_s;
  logic [2:0]          cti_s;
  logic [1:0]          bte_s;
  logic                win_req_s;
  logic                win_rdy_s;
  logic                inc_s;
  logic                last_s;

  rr_arbiter #(
    .NR_PORTS (NR_PORTS),
    .PW       (PW)
  ) u_arb (
    .req_i (req_i),
    .ptr_i (ptr_s),
    .gnt_o (arb_gnt_s)
  );

  // Select the granted port's address, cycle type and burst type; zero when idle.
  always_comb begin
    adr_s = 4'b0000;
    cti_s = 3'b000;
    bte_s = 2'b00;
    for (int n = 0; n < NR_PORTS; n++) begin
      adr_s = adr_s | (adr_i[4*n +: 4] & {4{gnt_q[n]}});
      cti_s = cti_s | (cti_i[3*n +: 3] & {3{gnt_q[n]}});
      bte_s = bte_s | (bte_i[2*n +: 2] & {2{gnt_q[n]}});
    end
  end

  assign win_req_s = |(req_i & gnt_q);
  assign win_rdy_s = |(~fifo_empty_i & gnt_q);
  assign inc_s     = (state_q == ST_BURST) && win_req_s && win_rdy_s;
  assign last_s    = cti_is_last(cti_s) || (done_i && (bte_s == BTE_LINEAR));

  // Next-state, next grant and init pulse for the burst sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    init_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_LOAD;
          gnt_d   = arb_gnt_s;
          init_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_BURST;
      end
      ST_BURST: begin
        // Winner withdrew or final beat went out: drop the grant now.
        if (!win_req_s || (inc_s && last_s)) begin
          state_d = ST_RELEASE;
          gnt_d   = {NR_PORTS{1'b0}};
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NR_PORTS{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, grant and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= {NR_PORTS{1'b0}};
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
    end
  end

`ifdef WB_SCHED_FIXED_PRIO_EN

  assign ptr_s = {PW{1'b0}};

`else

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx_s;

  // Binary index of the current winner.
  always_comb begin
    win_idx_s = {PW{1'b0}};
    for (int n = 0; n < NR_PORTS; n++) begin
      if (gnt_q[n]) begin
        win_idx_s = PW'(n);
      end else begin
        win_idx_s = win_idx_s;
      end
    end
  end

  // Advance the pointer past the winner as the burst is released.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == ST_BURST) && (state_d == ST_RELEASE)) begin
      if (win_idx_s == PW'(NR_PORTS - 1)) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = win_idx_s + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;

`endif

  assign init_o = init_q;
  assign busy_o = busy_q;
  assign gnt_o  = gnt_q;
  assign inc_o  = inc_s;
  assign ack_o  = gnt_q & {NR_PORTS{inc_s}};
  assign adr_o  = adr_s;
  assign cti_o  = cti_s;
  assign bte_o  = bte_s;

endmodule
